// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard_rx
// Purpose  : PS/2 keyboard receiver. Synchronises the keyboard clock into the
//            system clock domain, deserialises 11-bit device-to-host frames
//            (start 0, 8 data bits LSB first, odd parity, stop 1) and stores
//            valid scan codes in an 8-slot FIFO (7 usable entries).
// Ports    :
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   ps2_clk     in   PS/2 clock from the keyboard (asynchronous to clk)
//   ps2_data    in   PS/2 data from the keyboard
//   nextdata_n  in   active-low pop request, honoured while ready=1
//   data[7:0]   out  scan code at the FIFO head (combinational)
//   ready       out  FIFO non-empty
//   overflow    out  sticky: FIFO became full or a frame was dropped;
//                    cleared by any pop
// Revision : 1.0  initial release
// ============================================================================
module ps2_keyboard_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow
);

    // Index of the stop bit within a frame; the buffer holds bits 0..9.
    localparam logic [3:0] c_STOP_IDX  = 4'd10;
    localparam int         c_FIFO_SLOTS = 8;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0] sync_q,     sync_d;
    logic [3:0] count_q,    count_d;
    logic [9:0] buffer_q,   buffer_d;
    logic [2:0] w_ptr_q,    w_ptr_d;
    logic [2:0] r_ptr_q,    r_ptr_d;
    logic       overflow_q, overflow_d;
    logic [7:0] fifo_q [c_FIFO_SLOTS];
    logic [7:0] fifo_d [c_FIFO_SLOTS];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic w_fall;
    logic w_frame_done;
    logic w_frame_ok;
    logic w_full;
    logic w_pop;
    logic w_write;
    logic w_drop;
    logic w_becomes_full;

    // sync_q[0] is the metastability stage; the edge is detected between the
    // two settled stages, older (sync_q[2]) high and newer (sync_q[1]) low.
    assign w_fall       = sync_q[2] & ~sync_q[1];
    assign w_frame_done = w_fall && (count_q == c_STOP_IDX);

    // The stop bit is never buffered: it is the live ps2_data at the strobe.
    assign w_frame_ok   = ~buffer_q[0] & ps2_data & (^buffer_q[9:1]);

    // One slot is always kept empty so that full and empty are distinct.
    assign w_full       = ((w_ptr_q + 3'd1) == r_ptr_q);
    assign w_pop        = ready & ~nextdata_n;
    assign w_write      = w_frame_done & w_frame_ok & ~w_full;
    assign w_drop       = w_frame_done & w_frame_ok &  w_full;

    // Six entries before a write means the write takes the last slot; with a
    // simultaneous pop the occupancy does not change, so it does not fill.
    assign w_becomes_full = w_write & ~w_pop & (r_ptr_q == (w_ptr_q + 3'd2));

    assign ready    = (w_ptr_q != r_ptr_q);
    assign data     = fifo_q[r_ptr_q];
    assign overflow = overflow_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        sync_d = {sync_q[1:0], ps2_clk};
    end

    always_comb begin
        count_d  = count_q;
        buffer_d = buffer_q;
        if (w_fall) begin
            if (count_q < c_STOP_IDX) begin
                buffer_d[count_q] = ps2_data;
                count_d           = count_q + 4'd1;
            end else begin
                // Stop bit reached: restart regardless of frame validity.
                count_d = 4'd0;
            end
        end
    end

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        for (int i = 0; i < c_FIFO_SLOTS; i++) begin
            fifo_d[i] = fifo_q[i];
        end
        if (w_write) begin
            fifo_d[w_ptr_q] = buffer_q[8:1];
            w_ptr_d         = w_ptr_q + 3'd1;
        end
        if (w_pop) begin
            r_ptr_d = r_ptr_q + 3'd1;
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (w_becomes_full || w_drop) begin
            overflow_d = 1'b1;
        end else if (w_pop) begin
            overflow_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= 3'b000;
            count_q    <= 4'd0;
            buffer_q   <= 10'd0;
            w_ptr_q    <= 3'd0;
            r_ptr_q    <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            count_q    <= count_d;
            buffer_q   <= buffer_d;
            w_ptr_q    <= w_ptr_d;
            r_ptr_q    <= r_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_FIFO_SLOTS; i++) begin
                fifo_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < c_FIFO_SLOTS; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_keyboard_rx
// Purpose  : Self-checking bench for ps2_keyboard_rx. Includes a behavioural
//            keyboard that sends 11-bit frames (30 ns low / 30 ns high per
//            bit). Expected scan codes are queued when sent and compared by a
//            monitor whenever the consumer pops an entry.
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_keyboard_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;

    logic       auto_pop = 1'b0;
    logic       manual_n = 1'b1;
    logic       prev_ready = 1'b0;

    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    assign nextdata_n = auto_pop ? ~ready : manual_n;

    always #5 clk = ~clk;

    ps2_keyboard_rx dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow)
    );

    // ------------------------------------------------------------------------
    // Keyboard model: sends up to nbits of a frame. Parity is odd unless
    // par_flip is set; start/stop values are selectable for error frames.
    // ------------------------------------------------------------------------
    task automatic send_frame(input logic [7:0] code, input logic par_flip,
                              input logic start_v, input logic stop_v,
                              input int nbits);
        logic [10:0] bits;
        bits = {stop_v, (~^code) ^ par_flip, code, start_v};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            ps2_clk  = 1'b0;
            #30;
            ps2_clk  = 1'b1;
            #30;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_ok(input logic [7:0] code, input logic expect_store);
        if (expect_store) exp_q.push_back(code);
        send_frame(code, 1'b0, 1'b0, 1'b1, 11);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        @(posedge clk);
        #1 manual_n = 1'b0;
        @(posedge clk);
        #1 manual_n = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: every consumed entry is compared against the queue head.
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            if (ready && !nextdata_n) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: got %02h, required no entry", data);
                end else begin
                    e = exp_q.pop_front();
                    if (data !== e) begin
                        errors++;
                        $display("FAIL pop_data: got %02h, required %02h", data, e);
                    end
                end
            end
            if (auto_pop && ready) begin
                checks++;
                if (prev_ready) begin
                    errors++;
                    $display("FAIL ready_pulse: got ready high 2 cycles, required 1");
                end
            end
        end
        prev_ready = ready;
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [7:0] stream [9];
        stream = '{8'h1C, 8'hF0, 8'h1C, 8'h1B, 8'hF0, 8'h1B, 8'h1B, 8'hF0, 8'h1B};

        // Reset
        #20;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_data", {24'd0, data}, 32'h00);
        rst = 1'b1;
        #20;
        check("post_rst_ready", {31'd0, ready}, 32'd0);
        check("post_rst_data", {24'd0, data}, 32'h00);

        // Make/break stream with nextdata_n tied to ~ready
        auto_pop = 1'b1;
        foreach (stream[i]) send_ok(stream[i], 1'b1);
        idle(10);
        check("stream_overflow", {31'd0, overflow}, 32'd0);
        check("stream_drained", exp_q.size(), 32'd0);
        auto_pop = 1'b0;

        // Parity error, then a valid frame
        send_frame(8'h1C, 1'b1, 1'b0, 1'b1, 11);
        idle(5);
        check("parity_drop", {31'd0, ready}, 32'd0);
        send_ok(8'h1B, 1'b1);
        idle(5);
        check("after_parity_ready", {31'd0, ready}, 32'd1);
        check("after_parity_data", {24'd0, data}, 32'h1B);
        pop_one();
        idle(3);
        check("after_parity_empty", {31'd0, ready}, 32'd0);

        // Bad stop bit and bad start bit
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 11);
        idle(5);
        check("bad_stop_drop", {31'd0, ready}, 32'd0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 11);
        idle(5);
        check("bad_start_drop", {31'd0, ready}, 32'd0);
        send_ok(8'h3C, 1'b1);
        idle(5);
        check("resync_ready", {31'd0, ready}, 32'd1);
        pop_one();
        idle(3);

        // FIFO fill: 7 entries fill it, the 8th is dropped
        for (int i = 1; i <= 7; i++) begin
            send_ok(i[7:0], 1'b1);
            idle(5);
            if (i == 6) check("fill6_overflow", {31'd0, overflow}, 32'd0);
        end
        check("fill7_ready", {31'd0, ready}, 32'd1);
        check("fill7_overflow", {31'd0, overflow}, 32'd1);
        send_ok(8'h08, 1'b0);
        idle(5);
        check("drop_overflow", {31'd0, overflow}, 32'd1);
        check("drop_head", {24'd0, data}, 32'h01);
        pop_one();
        idle(2);
        check("overflow_clear", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            pop_one();
            idle(2);
        end
        check("fill_drained_ready", {31'd0, ready}, 32'd0);
        check("fill_drained_q", exp_q.size(), 32'd0);

        // Reset in the middle of a frame
        auto_pop = 1'b1;
        send_frame(8'h77, 1'b0, 1'b0, 1'b1, 5);
        rst = 1'b0;
        #20;
        check("midrst_ready", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        #20;
        send_ok(8'h2A, 1'b1);
        idle(10);
        check("midrst_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 keyboard receiver (`ps2_keyboard`). It samples the external PS/2 clock and data lines in the system clock domain and deserialises 11-bit device-to-host frames. Valid scan codes go into an 8-slot FIFO, which a consumer drains through a ready/next-data handshake. It sits between the keyboard pins and the scan-code decoding logic. A behavioural companion, `ps2_keyboard_model`, drives frames for simulation.

## Interface
- No parameters. The FIFO depth is fixed at 8 slots, which gives 7 usable entries.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ps2_clk  in  1  PS/2 clock from the keyboard; asynchronous to clk.
- ps2_data  in  1  PS/2 data from the keyboard; sampled on ps2_clk falling edges.
- nextdata_n  in  1  active-low pop request; each clk cycle with nextdata_n=0 and ready=1 consumes one entry.
- data  out  8  scan code at the FIFO head, driven combinationally from fifo[r_ptr].
- ready  out  1  FIFO non-empty (w_ptr != r_ptr).
- overflow  out  1  sticky flag: the FIFO became full.

## Operation
- Synchroniser: a 3-bit shift register samples ps2_clk every clk cycle. The falling-edge strobe is sampled=1 on the older stage and 0 on the newer stage.
- Frame format: start bit 0, then 8 data bits LSB first, then odd parity, then stop bit 1. That is 11 bits in total.
- Bit capture:
  - A 4-bit counter (0..10) and a 10-bit buffer record the bits.
  - On each falling-edge strobe with count<10: buffer[count] <= ps2_data, then count++.
- Frame completion, on the falling-edge strobe with count==10 (the stop bit):
  - The frame is valid when buffer[0]==0, ps2_data==1, and the XOR of buffer[9:1] is 1 (odd parity).
  - If valid and the FIFO is not full: fifo[w_ptr] <= buffer[8:1], then w_ptr++.
  - count <= 0 whether the frame was valid or not.
  - Invalid frames are silently discarded.
- Full condition: w_ptr+1 == r_ptr, with 3-bit wrap. A valid frame arriving while the FIFO is full is dropped and w_ptr is unchanged.
- Overflow:
  - Set when a write makes the FIFO full (r_ptr == w_ptr+2 before the write) or a frame is dropped.
  - Cleared on any pop.
- Pop: if ready and nextdata_n==0, r_ptr++ in that cycle. data then shows the next entry on the following cycle.
- Simultaneous write and pop in the same cycle: both pointers update, and the occupancy is unchanged.
- Reset (asynchronous, rst=0) sets:
  - count=0, w_ptr=0, r_ptr=0, overflow=0, synchroniser=0, buffer=0, all FIFO entries=0.
  - Therefore ready=0 and data=8'h00.
- Mid-frame reset aborts the partial frame. After release, bit capture restarts at count=0.
- ps2_keyboard_model, behavioural companion:
  - ps2_clk and ps2_data idle high.
  - Task kbd_sendcode(code) drives the start bit, code LSB first, odd parity, and stop bit.
  - For each bit: set data, then drive ps2_clk low for 30 ns, then high for 30 ns (60 ns bit period).

## Timing
- The falling-edge strobe fires 2-3 clk cycles after ps2_clk falls.
- ready rises one clk after the stop-bit strobe.
- Pop latency: r_ptr advances at the clk edge where nextdata_n=0 and ready=1. ready falls on that same edge if the FIFO empties.
- With nextdata_n tied to ~ready:
  - Each received byte appears for exactly one cycle.
  - ready pulses high for one cycle per byte.
- The ps2_clk high and low phases must each be ≥3 clk periods.

## Test plan
- Reset: hold rst=0 for 20 ns → ready=0, overflow=0, data=8'h00. Release and wait 20 ns → outputs stay unchanged.
- Make/break sequence: model sends 1C, F0, 1C, 1B, F0, 1B, 1B, F0, 1B, with nextdata_n=~ready → consumer captures exactly 1C, F0, 1C, 1B, F0, 1B, 1B, F0, 1B in order, one ready pulse per byte, overflow stays 0.
- Parity error: frame with code 8'h1C and even parity → no write, ready stays 0. The next valid 8'h1B is received correctly.
- Bad stop or start bit: stop=0 or start=1 → frame discarded, count returns to 0.
- FIFO fill: nextdata_n=1, send 7 codes 01..07 → ready=1, overflow=1 after the 7th. An 8th code (08) is dropped. Then pop with nextdata_n low for one cycle per pop → data yields 01..07 in order, overflow clears on the first pop.
- Reset mid-frame: rst=0 after 5 bits, then a full frame of 8'h2A → exactly 2A received.
